coeffs_hs_tx: RTL and testbench

//  Source-side end of the coefficient clock-domain-crossing (CDC) link.

---
 rtl/coeffs_cdc_pkg.sv | 12 +
 rtl/coeffs_hs_tx_chk.sv | 16 +
 rtl/coeffs_hs_tx_sync_ff.sv | 24 ++
 rtl/coeffs_hs_tx.sv | 147 ++++++++++++++
 tb/tb_coeffs_hs_tx.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/coeffs_cdc_pkg.sv
// Shared types and limits for the coefficient CDC link.
package coeffs_cdc_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        REQ          = 2'd1,
        WAIT_ACK_LOW = 2'd2
    } hs_state_t;

    localparam int NSYNC_MIN = 2;

endpackage

// File: rtl/coeffs_hs_tx_chk.sv
// Protocol checker for the coefficient link: data must not move while a request is outstanding.
module coeffs_hs_tx_chk #(
    parameter int NB = 8
) (
    input logic          i_clock,
    input logic          i_reset,
    input logic          req,
    input logic [NB-1:0] data
);

    a_data_stable : assert property (
        @(posedge i_clock) disable iff (i_reset)
        (req && $past(req)) |-> $stable(data)
    );

endmodule

// File: rtl/coeffs_hs_tx_sync_ff.sv
// Single-bit multi-flop synchroniser; the first stage is the only one that may go metastable.
module sync_ff #(
    parameter int NSTG = 2
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic [NSTG-1:0] stg_r;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            stg_r <= {NSTG{1'b0}};
        end else begin
            stg_r <= {stg_r[NSTG-2:0], i_d};
        end
    end

    assign o_q = stg_r[NSTG-1];

endmodule

// File: rtl/coeffs_hs_tx.sv
// Source side of the coefficient CDC link: latest-wins pending buffer feeding a 4-phase req/ack handshake.
// Optional build macro COEFFS_TX_PARITY_EN adds o_parity (even parity of o_data).
module coeffs_hs_tx
    import coeffs_cdc_pkg::*;
#(
    parameter int NB     = 8,
    parameter int NSYNC  = 2,
    parameter int NB_CNT = 8
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [NB-1:0]     i_coeffs,
    input  logic              i_valid,
    input  logic              i_ack,
    output logic              o_req,
    output logic [NB-1:0]     o_data,
    output logic              o_busy,
`ifdef COEFFS_TX_PARITY_EN
    output logic              o_parity,
`endif
    output logic [NB_CNT-1:0] o_drop_cnt
);

    localparam int              NSYNC_EFF = (NSYNC < NSYNC_MIN) ? NSYNC_MIN : NSYNC;
    localparam logic [NB_CNT-1:0] DROP_MAX = {NB_CNT{1'b1}};
    localparam logic [NB_CNT-1:0] DROP_ONE = {{(NB_CNT-1){1'b0}}, 1'b1};

    function automatic logic even_par(input logic [NB-1:0] v);
        even_par = ^v;
    endfunction

    hs_state_t          state_r, state_nx_s;
    logic [NB-1:0]      pend_r, pend_nx_s;
    logic               pend_v_r, pend_v_nx_s;
    logic               req_r, req_nx_s;
    logic [NB-1:0]      data_r, data_nx_s;
    logic [NB_CNT-1:0]  drop_cnt_r, drop_cnt_nx_s;
    logic               launch_s;
    logic               ack_s;

    sync_ff #(.NSTG(NSYNC_EFF)) u_ack_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_d     (i_ack),
        .o_q     (ack_s)
    );

    // Handshake sequencing: a new req only launches from IDLE, so ack must be seen low first.
    always_comb begin
        state_nx_s = state_r;
        req_nx_s   = req_r;
        data_nx_s  = data_r;
        launch_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (pend_v_r) begin
                    launch_s   = 1'b1;
                    req_nx_s   = 1'b1;
                    data_nx_s  = pend_r;
                    state_nx_s = REQ;
                end else begin
                    req_nx_s   = 1'b0;
                end
            end
            REQ: begin
                if (ack_s) begin
                    req_nx_s   = 1'b0;
                    state_nx_s = WAIT_ACK_LOW;
                end else begin
                    req_nx_s   = 1'b1;
                end
            end
            WAIT_ACK_LOW: begin
                req_nx_s = 1'b0;
                if (!ack_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = WAIT_ACK_LOW;
                end
            end
            default: begin
                req_nx_s   = 1'b0;
                state_nx_s = IDLE;
            end
        endcase
    end

    // Pending buffer and drop counting; an update only counts as dropped if the old one was not launched.
    always_comb begin
        pend_nx_s     = pend_r;
        pend_v_nx_s   = pend_v_r;
        drop_cnt_nx_s = drop_cnt_r;
        if (i_valid) begin
            pend_nx_s   = i_coeffs;
            pend_v_nx_s = 1'b1;
        end else if (launch_s) begin
            pend_v_nx_s = 1'b0;
        end else begin
            pend_v_nx_s = pend_v_r;
        end
        if (i_valid && pend_v_r && !launch_s && (drop_cnt_r != DROP_MAX)) begin
            drop_cnt_nx_s = drop_cnt_r + DROP_ONE;
        end else begin
            drop_cnt_nx_s = drop_cnt_r;
        end
    end

    // State and output registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_r    <= IDLE;
            pend_r     <= {NB{1'b0}};
            pend_v_r   <= 1'b0;
            req_r      <= 1'b0;
            data_r     <= {NB{1'b0}};
            drop_cnt_r <= {NB_CNT{1'b0}};
        end else begin
            state_r    <= state_nx_s;
            pend_r     <= pend_nx_s;
            pend_v_r   <= pend_v_nx_s;
            req_r      <= req_nx_s;
            data_r     <= data_nx_s;
            drop_cnt_r <= drop_cnt_nx_s;
        end
    end

`ifdef COEFFS_TX_PARITY_EN
    logic parity_r;

    // Parity is registered alongside o_data so both change on the same edge.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            parity_r <= 1'b0;
        end else begin
            parity_r <= even_par(data_nx_s);
        end
    end

    assign o_parity = parity_r;
`endif

    assign o_req      = req_r;
    assign o_data     = data_r;
    assign o_drop_cnt = drop_cnt_r;
    assign o_busy     = (state_r != IDLE) | pend_v_r;

endmodule

// File: tb/tb_coeffs_hs_tx.sv
// Randomised + directed bench for coeffs_hs_tx against a transaction-level model of the link.
module tb_coeffs_hs_tx;

    localparam int NB       = 8;
    localparam int NSYNC    = 2;
    localparam int NB_CNT   = 4;
    localparam int DROP_SAT = (1 << NB_CNT) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NB-1:0]     i_coeffs;
    logic              i_valid;
    logic              i_ack;
    logic              o_req;
    logic [NB-1:0]     o_data;
    logic              o_busy;
    logic [NB_CNT-1:0] o_drop_cnt;
`ifdef COEFFS_TX_PARITY_EN
    logic              o_parity;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    coeffs_hs_tx #(.NB(NB), .NSYNC(NSYNC), .NB_CNT(NB_CNT)) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_coeffs   (i_coeffs),
        .i_valid    (i_valid),
        .i_ack      (i_ack),
        .o_req      (o_req),
        .o_data     (o_data),
        .o_busy     (o_busy),
`ifdef COEFFS_TX_PARITY_EN
        .o_parity   (o_parity),
`endif
        .o_drop_cnt (o_drop_cnt)
    );

    coeffs_hs_tx_chk #(.NB(NB)) u_chk (
        .i_clock (clk),
        .i_reset (rst),
        .req     (o_req),
        .data    (o_data)
    );

    // Link model: a request is "in flight" from launch until ack has been seen low again.
    typedef struct packed {
        logic            req;
        logic            wait_lo;
        logic            pend_v;
        logic [NB-1:0]   data;
        logic [NB-1:0]   pend;
        logic [NSYNC-1:0] ackh;
        int              drops;
    } mstate_t;

    function automatic mstate_t step(input mstate_t s, input logic v, input logic [NB-1:0] c, input logic a);
        mstate_t n;
        logic    ack_seen;
        logic    launched;
        n        = s;
        ack_seen = s.ackh[NSYNC-1];
        n.ackh   = {s.ackh[NSYNC-2:0], a};
        launched = !s.req && !s.wait_lo && s.pend_v;
        if (v && s.pend_v && !launched && s.drops < DROP_SAT) n.drops = s.drops + 1;
        if (launched) begin
            n.req    = 1'b1;
            n.data   = s.pend;
            n.pend_v = 1'b0;
        end else if (s.req && ack_seen) begin
            n.req     = 1'b0;
            n.wait_lo = 1'b1;
        end else if (s.wait_lo && !ack_seen) begin
            n.wait_lo = 1'b0;
        end
        if (v) begin
            n.pend   = c;
            n.pend_v = 1'b1;
        end
        return n;
    endfunction

    mstate_t m;

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '0;
        else     m <= step(m, i_valid, i_coeffs, i_ack);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("req",  32'(o_req),      32'(m.req));
            chk("data", 32'(o_data),     32'(m.data));
            chk("busy", 32'(o_busy),     32'(m.req | m.wait_lo | m.pend_v));
            chk("drop", 32'(o_drop_cnt), 32'(m.drops));
`ifdef COEFFS_TX_PARITY_EN
            chk("parity", 32'(o_parity), 32'(^m.data));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [NB-1:0] v);
        i_valid  = 1'b1;
        i_coeffs = v;
        tick();
        i_valid  = 1'b0;
    endtask

    task automatic wait_req(input logic lvl);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (o_req === lvl) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_req timeout actual=%0b required=%0b", o_req, lvl);
        end
    endtask

    task automatic handshake(output logic [NB-1:0] sent);
        wait_req(1'b1);
        sent  = o_data;
        i_ack = 1'b1;
        wait_req(1'b0);
        i_ack = 1'b0;
        repeat (4) tick();
    endtask

    logic [NB-1:0] s;

    initial begin
        rst      = 1'b1;
        i_valid  = 1'b0;
        i_coeffs = 8'h00;
        i_ack    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req",  32'(o_req),      32'd0);
        chk("rst_data", 32'(o_data),     32'h00);
        chk("rst_drop", 32'(o_drop_cnt), 32'd0);
        chk("rst_busy", 32'(o_busy),     32'd0);
        rst = 1'b0;
        tick();

        // Basic send, latency and ack synchroniser delay
        pulse(8'hAA);
        chk("lat_req_k", 32'(o_req), 32'd0);
        tick();
        chk("lat_req_k1", 32'(o_req),  32'd1);
        chk("lat_data",   32'(o_data), 32'hAA);
        repeat (5) tick();
        chk("hold_data", 32'(o_data), 32'hAA);
        i_ack = 1'b1;
        tick();
        tick();
        chk("ack_edge2_req", 32'(o_req), 32'd1);
        tick();
        chk("ack_edge3_req", 32'(o_req), 32'd0);
        i_ack = 1'b0;
        repeat (4) tick();
        chk("idle_busy", 32'(o_busy), 32'd0);

        // Queued update during REQ is sent after, no drop
        pulse(8'h11);
        tick();
        pulse(8'h22);
        handshake(s);
        chk("q_first", 32'(s), 32'h11);
        handshake(s);
        chk("q_second", 32'(s), 32'h22);
        chk("q_drop", 32'(o_drop_cnt), 32'd0);

        // Overwrites during REQ: latest wins
        pulse(8'h10);
        tick();
        pulse(8'h33);
        pulse(8'h44);
        pulse(8'h55);
        handshake(s);
        chk("ow_first", 32'(s), 32'h10);
        handshake(s);
        chk("ow_latest", 32'(s), 32'h55);
        chk("ow_drop", 32'(o_drop_cnt), 32'd2);

        // Saturation of the drop counter
        pulse(8'h01);
        tick();
        repeat (20) pulse(8'($urandom));
        chk("sat_drop", 32'(o_drop_cnt), 32'd15);
        handshake(s);
        handshake(s);
        chk("sat_hold", 32'(o_drop_cnt), 32'd15);

        // Spurious ack while idle
        i_ack = 1'b1;
        repeat (5) tick();
        chk("spur_req",  32'(o_req),  32'd0);
        chk("spur_busy", 32'(o_busy), 32'd0);
        i_ack = 1'b0;
        repeat (3) tick();

        // Reset mid-transfer with data pending
        pulse(8'h77);
        tick();
        chk("mid_req",  32'(o_req),  32'd1);
        chk("mid_data", 32'(o_data), 32'h77);
        pulse(8'h88);
        #3;
        rst = 1'b1;
        #1;
        chk("async_req",  32'(o_req),  32'd0);
        chk("async_busy", 32'(o_busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_req", 32'(o_req), 32'd0);
        end

`ifdef COEFFS_TX_PARITY_EN
        pulse(8'h07);
        tick();
        chk("par_07", 32'(o_parity), 32'd1);
        handshake(s);
        pulse(8'h03);
        tick();
        chk("par_03", 32'(o_parity), 32'd0);
        handshake(s);
`endif

        // Random traffic with a lazy receiver
        for (int i = 0; i < 500; i++) begin
            if ((o_req !== i_ack) && ($urandom_range(0, 3) == 0)) i_ack = o_req;
            i_valid  = ($urandom_range(0, 4) == 0);
            i_coeffs = 8'($urandom);
            tick();
        end
        i_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (o_req !== i_ack) i_ack = o_req;
            tick();
        end
        chk("drain_busy", 32'(o_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
